// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles, branch flushes, dmem waits.
// Optional perf counters (lu_cnt, mem_cnt, flush_cnt) are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int LU_BUBBLES  = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       branch_taken_EX,
    input  logic       dmem_req_MEM,
    input  logic       dmem_ready,
    input  logic       imem_ready,
    output logic       en_PC,
    output logic       en_IF_ID,
    output logic       en_ID_EX,
    output logic       en_EX_MEM,
    output logic       en_MEM_WB,
    output logic       flush_IF_ID,
    output logic       flush_ID_EX,
    output logic       bubble_EX,
    output logic       pc_redirect,
    output logic [1:0] state,
    output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mem_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int BW = (LU_BUBBLES > 1) ? $clog2(LU_BUBBLES) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

    if (LU_BUBBLES < 1 || MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipeline_hazard_ctrl: parameters must all be >= 1");
    end

    typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2} state_e;

    state_e          state_q, state_d, mode;
    logic            ret_lu_q, ret_lu_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            mem_timeout_q, mem_timeout_d;
    logic            mem_busy;

    assign mem_busy    = dmem_req_MEM & ~dmem_ready;
    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;

    always_comb begin
        {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB} = 5'b00000;
        {flush_IF_ID, flush_ID_EX} = 2'b00;
        bubble_EX   = 1'b0;
        pc_redirect = 1'b0;
        state_d     = state_q;
        ret_lu_d    = ret_lu_q;
        bcnt_d      = bcnt_q;
        // A completed wait replays the state it interrupted, in the same cycle.
        mode = state_q;
        if (state_q == MEM_WAIT && dmem_ready)
            mode = ret_lu_q ? LU_STALL : RUN;
        case (mode)
            RUN: begin
                if (mem_busy) begin
                    state_d  = MEM_WAIT;
                    ret_lu_d = 1'b0;
                end else if (stall) begin
                    {en_EX_MEM, en_MEM_WB} = 2'b11;
                    bubble_EX = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        state_d = LU_STALL;
                        bcnt_d  = BW'(LU_BUBBLES - 1);
                    end else begin
                        state_d = RUN;
                    end
                end else if (branch_taken_EX) begin
                    {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB} = 5'b11111;
                    {flush_IF_ID, flush_ID_EX} = 2'b11;
                    pc_redirect = 1'b1;
                    state_d     = RUN;
                end else if (!imem_ready) begin
                    {en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB} = 4'b1111;
                    flush_IF_ID = 1'b1;
                    state_d     = RUN;
                end else begin
                    {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB} = 5'b11111;
                    state_d = RUN;
                end
            end
            LU_STALL: begin
                if (mem_busy) begin
                    state_d  = MEM_WAIT;
                    ret_lu_d = 1'b1;
                end else begin
                    {en_EX_MEM, en_MEM_WB} = 2'b11;
                    bubble_EX = 1'b1;
                    bcnt_d    = bcnt_q - 1'b1;
                    state_d   = (bcnt_q == BW'(1)) ? RUN : LU_STALL;
                end
            end
            default: ;
        endcase
        if (rst) begin
            {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB} = 5'b00000;
            {flush_IF_ID, flush_ID_EX} = 2'b11;
            bubble_EX   = 1'b0;
            pc_redirect = 1'b0;
            state_d     = RUN;
            ret_lu_d    = 1'b0;
            bcnt_d      = '0;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (!rst && mem_busy)
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        mem_timeout_d = !rst && (mem_timeout_q || wait_cnt_d == WAIT_MAX);
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        ret_lu_q      <= ret_lu_d;
        bcnt_q        <= bcnt_d;
        wait_cnt_q    <= wait_cnt_d;
        mem_timeout_q <= mem_timeout_d;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, mem_cnt_q, mem_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        lu_cnt_d    = lu_cnt_q;
        mem_cnt_d   = mem_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bubble_EX && lu_cnt_q != '1)      lu_cnt_d    = lu_cnt_q + 1'b1;
        if (mem_busy && mem_cnt_q != '1)      mem_cnt_d   = mem_cnt_q + 1'b1;
        if (pc_redirect && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        if (rst) begin
            lu_cnt_d    = '0;
            mem_cnt_d   = '0;
            flush_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        lu_cnt_q    <= lu_cnt_d;
        mem_cnt_q   <= mem_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign lu_cnt    = lu_cnt_q;
    assign mem_cnt   = mem_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector bench for pipeline_hazard_ctrl: u3 (LU_BUBBLES=3) via table, u1 (LU_BUBBLES=1) via short sequence.
module tb_pipeline_hazard_ctrl;

    // in  = {rst, stall, branch_taken_EX, dmem_req_MEM, dmem_ready, imem_ready}
    // exp = {en PC,IF_ID,ID_EX,EX_MEM,MEM_WB, flush IF_ID,ID_EX, bubble_EX, pc_redirect, state[1:0], mem_timeout}
    typedef struct packed {
        logic [5:0]  in;
        logic [11:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst, stall, br, dreq, drdy, irdy;
    wire [4:0] en3, en1;
    wire [1:0] fl3, fl1, st3, st1;
    wire       bub3, bub1, red3, red1, to3, to1;
    wire [11:0] act3 = {en3, fl3, bub3, red3, st3, to3};
    wire [11:0] act1 = {en1, fl1, bub1, red1, st1, to1};
    int n_tests = 0, n_fail = 0;

`ifdef HAZARD_PERF_CNT_EN
    wire [31:0] lu3, mem3, fc3, lu1, mem1, fc1;
    logic [31:0] lu_snap, mem_snap;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LU_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(32)) u3 (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken_EX(br), .dmem_req_MEM(dreq),
        .dmem_ready(drdy), .imem_ready(irdy),
        .en_PC(en3[4]), .en_IF_ID(en3[3]), .en_ID_EX(en3[2]), .en_EX_MEM(en3[1]), .en_MEM_WB(en3[0]),
        .flush_IF_ID(fl3[1]), .flush_ID_EX(fl3[0]), .bubble_EX(bub3), .pc_redirect(red3),
        .state(st3), .mem_timeout(to3)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_cnt(lu3), .mem_cnt(mem3), .flush_cnt(fc3)
`endif
    );

    pipeline_hazard_ctrl #(.LU_BUBBLES(1), .MEM_TIMEOUT(4), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken_EX(br), .dmem_req_MEM(dreq),
        .dmem_ready(drdy), .imem_ready(irdy),
        .en_PC(en1[4]), .en_IF_ID(en1[3]), .en_ID_EX(en1[2]), .en_EX_MEM(en1[1]), .en_MEM_WB(en1[0]),
        .flush_IF_ID(fl1[1]), .flush_ID_EX(fl1[0]), .bubble_EX(bub1), .pc_redirect(red1),
        .state(st1), .mem_timeout(to1)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_cnt(lu1), .mem_cnt(mem1), .flush_cnt(fc1)
`endif
    );

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %b want %b", nm, idx, act, exp);
        end
    endtask

    vec_t tbl[33];
    vec_t seq1[5];

    initial begin
        tbl[0]  = '{6'b100001, 12'b00000_11_0_0_00_0};  // reset
        tbl[1]  = '{6'b100001, 12'b00000_11_0_0_00_0};
        tbl[2]  = '{6'b000001, 12'b11111_00_0_0_00_0};  // run
        tbl[3]  = '{6'b000000, 12'b01111_10_0_0_00_0};  // imem not ready
        tbl[4]  = '{6'b010001, 12'b00011_00_1_0_00_0};  // 3-bubble load-use
        tbl[5]  = '{6'b000001, 12'b00011_00_1_0_01_0};
        tbl[6]  = '{6'b000001, 12'b00011_00_1_0_01_0};
        tbl[7]  = '{6'b000001, 12'b11111_00_0_0_00_0};
        tbl[8]  = '{6'b011001, 12'b00011_00_1_0_00_0};  // stall beats branch
        tbl[9]  = '{6'b001001, 12'b00011_00_1_0_01_0};  // branch ignored in LU_STALL
        tbl[10] = '{6'b000001, 12'b00011_00_1_0_01_0};
        tbl[11] = '{6'b001001, 12'b11111_11_0_1_00_0};  // branch redirect
        tbl[12] = '{6'b001000, 12'b11111_11_0_1_00_0};  // branch beats imem stall
        tbl[13] = '{6'b000001, 12'b11111_00_0_0_00_0};
        tbl[14] = '{6'b010001, 12'b00011_00_1_0_00_0};  // bubble 1
        tbl[15] = '{6'b000101, 12'b00000_00_0_0_01_0};  // busy in LU_STALL
        tbl[16] = '{6'b000101, 12'b00000_00_0_0_10_0};
        tbl[17] = '{6'b000111, 12'b00011_00_1_0_10_0};  // ready: bubble 2
        tbl[18] = '{6'b000001, 12'b00011_00_1_0_01_0};  // bubble 3
        tbl[19] = '{6'b000001, 12'b11111_00_0_0_00_0};
        tbl[20] = '{6'b000101, 12'b00000_00_0_0_00_0};  // timeout run, busy cycle 0
        tbl[21] = '{6'b000101, 12'b00000_00_0_0_10_0};
        tbl[22] = '{6'b000101, 12'b00000_00_0_0_10_0};
        tbl[23] = '{6'b000101, 12'b00000_00_0_0_10_0};
        tbl[24] = '{6'b000101, 12'b00000_00_0_0_10_1};  // timeout visible cycle 4
        tbl[25] = '{6'b000111, 12'b11111_00_0_0_10_1};
        tbl[26] = '{6'b000001, 12'b11111_00_0_0_00_1};
        tbl[27] = '{6'b010101, 12'b00000_00_0_0_00_1};  // busy beats stall
        tbl[28] = '{6'b010111, 12'b00011_00_1_0_10_1};  // wait resolves into RUN stall
        tbl[29] = '{6'b000001, 12'b00011_00_1_0_01_1};
        tbl[30] = '{6'b100001, 12'b00000_11_0_0_01_1};  // reset mid-bubble
        tbl[31] = '{6'b100001, 12'b00000_11_0_0_00_0};
        tbl[32] = '{6'b000001, 12'b11111_00_0_0_00_0};

        seq1[0] = '{6'b010001, 12'b00011_00_1_0_00_0};  // single bubble
        seq1[1] = '{6'b000001, 12'b11111_00_0_0_00_0};
        seq1[2] = '{6'b011001, 12'b00011_00_1_0_00_0};  // stall+branch: no redirect
        seq1[3] = '{6'b001001, 12'b11111_11_0_1_00_0};  // then branch alone
        seq1[4] = '{6'b000001, 12'b11111_00_0_0_00_0};

        {rst, stall, br, dreq, drdy, irdy} = 6'b100001;
        @(posedge clk); #1;

        for (int i = 0; i < 33; i++) begin
            {rst, stall, br, dreq, drdy, irdy} = tbl[i].in;
            @(negedge clk);
            chk("u3_vec", i, 32'(act3), 32'(tbl[i].exp));
`ifdef HAZARD_PERF_CNT_EN
            if (i == 14) begin
                lu_snap  = lu3;
                mem_snap = mem3;
                chk("u3_flush_cnt", i, fc3, 32'd2);
            end
            if (i == 20) begin
                chk("u3_lu_cnt_delta", i, lu3 - lu_snap, 32'd3);
                chk("u3_mem_cnt_delta", i, mem3 - mem_snap, 32'd2);
            end
`endif
            @(posedge clk); #1;
        end

        for (int i = 0; i < 5; i++) begin
            {rst, stall, br, dreq, drdy, irdy} = seq1[i].in;
            @(negedge clk);
            chk("u1_seq", i, 32'(act1), 32'(seq1[i].exp));
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
